cory_route_sched: RTL and testbench



---
 rtl/cory_route_sched_if.sv | 26 ++
 rtl/cory_route_sched.sv | 158 +++++++++++++++
 tb/tb_cory_route_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cory_route_sched_if.sv
// Request/grant/selector bundle between the cory_route input ports and the allocation scheduler.
// master drives requests and beat acceptance; slave (the scheduler) drives grants and selectors.
interface cory_route_sched_if #(
   parameter int unsigned S = 2,
   parameter int unsigned R = 2**S,
   parameter int unsigned E = S*R
);
   logic [R-1:0] i_req_v;
   logic [E-1:0] i_req_dst;
   logic [R-1:0] i_req_last;
   logic [R-1:0] i_fire;
   logic [R-1:0] o_gnt;
   logic [E-1:0] o_z_s;
   logic [R-1:0] o_z_en;
   logic         o_err;

   modport master (
      output i_req_v, i_req_dst, i_req_last, i_fire,
      input  o_gnt, o_z_s, o_z_en, o_err
   );

   modport slave (
      input  i_req_v, i_req_dst, i_req_last, i_fire,
      output o_gnt, o_z_s, o_z_en, o_err
   );
endinterface

// File: rtl/cory_route_sched.sv
// Per-output round-robin allocator for the cory_route crossbar; locks an output until last beat.
// Optional per-output lock watchdog with sticky error: define CORY_ROUTE_SCHED_WDOG_EN.
module cory_route_sched #(
   parameter int unsigned S = 2,
   parameter int unsigned R = 2**S,
   parameter int unsigned E = S*R,
   parameter int unsigned W = 8
) (
   input logic              clk,
   input logic              reset,
   cory_route_sched_if.slave bus
);
   typedef enum logic [0:0] {StIdle, StBusy} state_e;
   typedef logic [S-1:0] idx_t;
   typedef logic [W-1:0] cnt_t;

   state_e state_q [R];
   state_e state_d [R];
   idx_t   sel_q [R];
   idx_t   sel_d [R];
   idx_t   ptr_q [R];
   idx_t   ptr_d [R];

   logic [R-1:0] gnt;
   logic [R-1:0] z_en;
   logic [E-1:0] z_s;

`ifdef CORY_ROUTE_SCHED_WDOG_EN
   cnt_t cnt_q [R];
   cnt_t cnt_d [R];
   logic err_q, err_d;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned j = 0; j < R; j++) begin
            state_q[j] <= StIdle;
            sel_q[j]   <= '0;
            ptr_q[j]   <= '0;
`ifdef CORY_ROUTE_SCHED_WDOG_EN
            cnt_q[j]   <= '0;
`endif
         end
`ifdef CORY_ROUTE_SCHED_WDOG_EN
         err_q <= 1'b0;
`endif
      end else begin
         for (int unsigned j = 0; j < R; j++) begin
            state_q[j] <= state_d[j];
            sel_q[j]   <= sel_d[j];
            ptr_q[j]   <= ptr_d[j];
`ifdef CORY_ROUTE_SCHED_WDOG_EN
            cnt_q[j]   <= cnt_d[j];
`endif
         end
`ifdef CORY_ROUTE_SCHED_WDOG_EN
         err_q <= err_d;
`endif
      end
   end

   always_comb begin
      logic found;
      idx_t k;
      found = 1'b0;
      k     = '0;
`ifdef CORY_ROUTE_SCHED_WDOG_EN
      err_d = err_q;
`endif
      for (int unsigned j = 0; j < R; j++) begin
         state_d[j] = state_q[j];
         sel_d[j]   = sel_q[j];
         ptr_d[j]   = ptr_q[j];
`ifdef CORY_ROUTE_SCHED_WDOG_EN
         cnt_d[j]   = cnt_q[j];
`endif
         unique case (state_q[j])
            StIdle: begin
               // Scan from ptr upward; inputs already holding another output are not candidates.
               found = 1'b0;
               for (int unsigned o = 0; o < R; o++) begin
                  k = ptr_q[j] + idx_t'(o);
                  if (!found && bus.i_req_v[k] && !gnt[k] &&
                      bus.i_req_dst[S*k +: S] == idx_t'(j)) begin
                     found    = 1'b1;
                     sel_d[j] = k;
                  end
               end
               if (found) begin
                  state_d[j] = StBusy;
                  ptr_d[j]   = idx_t'(sel_d[j] + 1'b1);
`ifdef CORY_ROUTE_SCHED_WDOG_EN
                  cnt_d[j]   = '0;
`endif
               end
            end
            StBusy: begin
               if (bus.i_fire[sel_q[j]] && bus.i_req_last[sel_q[j]]) begin
                  state_d[j] = StIdle;
               end
`ifdef CORY_ROUTE_SCHED_WDOG_EN
               else if (bus.i_fire[sel_q[j]]) begin
                  cnt_d[j] = '0;
               end else if (cnt_t'(cnt_q[j] + 1'b1) == '1) begin
                  state_d[j] = StIdle;
                  err_d      = 1'b1;
               end else begin
                  cnt_d[j] = cnt_t'(cnt_q[j] + 1'b1);
               end
`endif
            end
         endcase
      end
   end

   always_comb begin
      gnt  = '0;
      z_en = '0;
      z_s  = '0;
      for (int unsigned j = 0; j < R; j++) begin
         z_s[S*j +: S] = sel_q[j];
         if (state_q[j] == StBusy) begin
            z_en[j]        = 1'b1;
            gnt[sel_q[j]]  = 1'b1;
         end
      end
   end

   assign bus.o_gnt  = gnt;
   assign bus.o_z_en = z_en;
   assign bus.o_z_s  = z_s;
`ifdef CORY_ROUTE_SCHED_WDOG_EN
   assign bus.o_err  = err_q;
`else
   assign bus.o_err  = 1'b0;
`endif

`ifdef SIM
   always_ff @(posedge clk) begin
      if (R != (1 << S)) begin
         $display("ERROR: cory_route_sched R=%0d does not equal 2**S", R);
         $finish;
      end
      if (!reset) begin
         for (int unsigned k = 0; k < R; k++) begin
            if (bus.i_fire[k] && !gnt[k]) begin
               $display("ERROR: cory_route_sched fire on ungranted input %0d", k);
            end
         end
         for (int unsigned j = 0; j < R; j++) begin
            if (state_q[j] == StBusy && bus.i_req_dst[S*sel_q[j] +: S] != idx_t'(j)) begin
               $display("ERROR: cory_route_sched input %0d changed dst while locked", sel_q[j]);
            end
         end
      end
   end
`endif
endmodule

// File: tb/tb_cory_route_sched.sv
// Directed bench for cory_route_sched: per-cycle comparison against a queue/array-level model
// plus hand-computed spot checks.
module tb_cory_route_sched;
   localparam int S = 2;
   localparam int R = 4;
   localparam int W = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   bit   cmp_on = 1'b0;

   cory_route_sched_if #(.S(S)) bus ();

   cory_route_sched #(.S(S), .W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, got running required finished");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: owner input per output (-1 when free), last selector, rr pointer.
   int m_own [R];
   int m_sel [R];
   int m_ptr [R];
   int m_run [R];
   bit m_err;

   initial begin
      for (int j = 0; j < R; j++) begin
         m_own[j] = -1; m_sel[j] = 0; m_ptr[j] = 0; m_run[j] = 0;
      end
      m_err = 1'b0;
   end

   always @(posedge clk) begin
      int old_own [R];
      bit owned [R];
      bit found;
      int k;
      old_own = m_own;
      if (reset) begin
         for (int j = 0; j < R; j++) begin
            m_own[j] = -1; m_sel[j] = 0; m_ptr[j] = 0; m_run[j] = 0;
         end
         m_err = 1'b0;
      end else begin
         for (int i = 0; i < R; i++) owned[i] = 1'b0;
         for (int j = 0; j < R; j++) if (old_own[j] >= 0) owned[old_own[j]] = 1'b1;
         for (int j = 0; j < R; j++) begin
            if (old_own[j] >= 0) begin
               if (bus.i_fire[old_own[j]] && bus.i_req_last[old_own[j]]) begin
                  m_own[j] = -1;
               end else begin
`ifdef CORY_ROUTE_SCHED_WDOG_EN
                  if (bus.i_fire[old_own[j]]) m_run[j] = 0;
                  else begin
                     m_run[j]++;
                     if (m_run[j] == (1 << W) - 1) begin
                        m_own[j] = -1;
                        m_err = 1'b1;
                     end
                  end
`endif
               end
            end else begin
               found = 1'b0;
               for (int o = 0; o < R; o++) begin
                  k = (m_ptr[j] + o) % R;
                  if (!found && bus.i_req_v[k] && !owned[k] && bus.i_req_dst[S*k +: S] == j) begin
                     found = 1'b1;
                     m_own[j] = k;
                     m_sel[j] = k;
                     m_ptr[j] = (k + 1) % R;
                     m_run[j] = 0;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [R-1:0] eg, ee;
      logic [2*R-1:0] es;
      if (cmp_on) begin
         eg = '0; ee = '0; es = '0;
         for (int j = 0; j < R; j++) begin
            es[S*j +: S] = m_sel[j][S-1:0];
            if (m_own[j] >= 0) begin
               ee[j] = 1'b1;
               eg[m_own[j]] = 1'b1;
            end
         end
         chk("model_gnt", 32'(bus.o_gnt), 32'(eg));
         chk("model_z_en", 32'(bus.o_z_en), 32'(ee));
         chk("model_z_s", 32'(bus.o_z_s), 32'(es));
         chk("model_err", 32'(bus.o_err), 32'(m_err));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dst(input int k, input int d);
      bus.i_req_dst[S*k +: S] = d[S-1:0];
   endtask

   int gk [4];
   int gc [4];
   int gcnt;
   int busy_cycles;

   initial begin
      bus.i_req_v = '0; bus.i_req_dst = '0; bus.i_req_last = '0; bus.i_fire = '0;
      reset = 1'b1;
      step();
      cmp_on = 1'b1;
      step();
      reset = 1'b0;

      // Idle, with a stray fire on an ungranted input.
      bus.i_fire = 4'b1000;
      step();
      bus.i_fire = '0;
      repeat (4) step();
      chk("idle_gnt", 32'(bus.o_gnt), 32'h0);
      chk("idle_z_en", 32'(bus.o_z_en), 32'h0);
      chk("idle_z_s", 32'(bus.o_z_s), 32'h0);

      // Input 2 -> output 1, three beats; valid drops for one cycle mid-packet.
      set_dst(2, 1);
      bus.i_req_v = 4'b0100;
      step();
      chk("pkt_gnt_c1", 32'(bus.o_gnt), 32'h4);
      chk("pkt_z_en_c1", 32'(bus.o_z_en), 32'h2);
      chk("pkt_z_s1_c1", 32'(bus.o_z_s[3:2]), 32'd2);
      bus.i_req_v = 4'b0000;
      step();
      chk("pkt_hold_gnt_c2", 32'(bus.o_gnt), 32'h4);
      bus.i_req_v = 4'b0100;
      bus.i_fire = 4'b0100;
      step();
      step();
      bus.i_req_last = 4'b0100;
      step();
      bus.i_fire = '0; bus.i_req_last = '0; bus.i_req_v = '0;
      chk("pkt_rel_gnt_c5", 32'(bus.o_gnt), 32'h0);
      chk("pkt_rel_z_en_c5", 32'(bus.o_z_en), 32'h0);
      chk("pkt_rel_z_s1_c5", 32'(bus.o_z_s[3:2]), 32'd2);

      // Inputs 0,1,3 contend for output 0 with single-beat packets.
      set_dst(0, 0); set_dst(1, 0); set_dst(3, 0);
      bus.i_req_v = 4'b1011;
      bus.i_req_last = 4'b1111;
      gcnt = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         bus.i_fire = bus.o_gnt;
         if (bus.o_gnt != 0 && gcnt < 4) begin
            for (int i = 0; i < R; i++) if (bus.o_gnt[i]) gk[gcnt] = i;
            gc[gcnt] = c;
            gcnt++;
         end
         if (c == 8) bus.i_req_v = '0;
      end
      bus.i_fire = '0; bus.i_req_last = '0;
      step();
      chk("rr_count", 32'(gcnt), 32'd4);
      chk("rr_order0", 32'(gk[0]), 32'd0);
      chk("rr_order1", 32'(gk[1]), 32'd1);
      chk("rr_order2", 32'(gk[2]), 32'd3);
      chk("rr_order3", 32'(gk[3]), 32'd0);
      for (int i = 0; i < 3; i++) chk("rr_spacing", 32'(gc[i+1] - gc[i]), 32'd2);

      // Two outputs granted in the same cycle.
      set_dst(0, 3); set_dst(1, 2);
      bus.i_req_v = 4'b0011;
      bus.i_req_last = 4'b0011;
      step();
      chk("par_gnt", 32'(bus.o_gnt), 32'h3);
      chk("par_z_en", 32'(bus.o_z_en), 32'hc);
      chk("par_z_s3", 32'(bus.o_z_s[7:6]), 32'd0);
      chk("par_z_s2", 32'(bus.o_z_s[5:4]), 32'd1);
      bus.i_fire = 4'b0011;
      step();
      bus.i_fire = '0; bus.i_req_v = '0; bus.i_req_last = '0;
      chk("par_rel_gnt", 32'(bus.o_gnt), 32'h0);
      step();

      // Reset while output 1 is mid-packet.
      set_dst(2, 1);
      bus.i_req_v = 4'b0100;
      step();
      chk("rst_pre_gnt", 32'(bus.o_gnt), 32'h4);
      bus.i_fire = 4'b0100;
      step();
      bus.i_fire = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_gnt", 32'(bus.o_gnt), 32'h0);
      chk("rst_z_en", 32'(bus.o_z_en), 32'h0);
      chk("rst_z_s", 32'(bus.o_z_s), 32'h0);
      step();
      chk("rst_regrant_gnt", 32'(bus.o_gnt), 32'h4);
      chk("rst_regrant_z_s1", 32'(bus.o_z_s[3:2]), 32'd2);
      bus.i_fire = 4'b0100; bus.i_req_last = 4'b0100;
      step();
      bus.i_fire = '0; bus.i_req_last = '0; bus.i_req_v = '0;
      step();

`ifdef CORY_ROUTE_SCHED_WDOG_EN
      // Input 1 holds output 0 without firing; watchdog frees it for input 2.
      set_dst(1, 0); set_dst(2, 0);
      bus.i_req_v = 4'b0110;
      step();
      chk("wd_gnt", 32'(bus.o_gnt), 32'h2);
      busy_cycles = 0;
      while (bus.o_gnt[1] && busy_cycles < 100) begin
         busy_cycles++;
         step();
      end
      chk("wd_busy_cycles", 32'(busy_cycles), 32'd15);
      chk("wd_err", 32'(bus.o_err), 32'd1);
      bus.i_req_v = 4'b0100;
      step();
      chk("wd_next_gnt", 32'(bus.o_gnt), 32'h4);
      bus.i_fire = 4'b0100; bus.i_req_last = 4'b0100;
      step();
      bus.i_fire = '0; bus.i_req_last = '0; bus.i_req_v = '0;
      repeat (3) step();
      chk("wd_err_sticky", 32'(bus.o_err), 32'd1);
`endif

      @(negedge clk);
      cmp_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
